// File: rtl/network_sequencer.sv
// Time-multiplexed 9-9-1 network evaluator: one shared MAC walks all 19 neurons in turn.
// Define NETWORK_SEQUENCER_RELU_EN to apply ReLU to hidden-layer results (default: linear).
`timescale 1ns/1ps
module network_sequencer #(
    parameter int DATA_W = 33,
    parameter int FRAC_W = 26,
    parameter int N_IN   = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic signed [DATA_W-1:0] input_0,
    input  logic signed [DATA_W-1:0] input_1,
    input  logic signed [DATA_W-1:0] input_2,
    input  logic signed [DATA_W-1:0] input_3,
    input  logic signed [DATA_W-1:0] input_4,
    input  logic signed [DATA_W-1:0] input_5,
    input  logic signed [DATA_W-1:0] input_6,
    input  logic signed [DATA_W-1:0] input_7,
    input  logic signed [DATA_W-1:0] input_8,
    input  logic                     cfg_we,
    input  logic [7:0]               cfg_addr,
    input  logic signed [DATA_W-1:0] cfg_wdata,
    output logic                     busy,
    output logic signed [DATA_W:0]   out,
    output logic                     end_
);

    localparam int N_W    = 2 * N_IN * N_IN + N_IN;
    localparam int PROD_W = 2 * DATA_W;
    localparam int ACC_W  = PROD_W + 6;
    localparam int OUT_W  = DATA_W + 1;

    localparam logic [4:0] FIRST_L1    = 5'(N_IN);
    localparam logic [4:0] LAST_NEURON = 5'(2 * N_IN);
    localparam logic [3:0] LAST_K      = 4'(N_IN - 1);
    localparam logic [7:0] LAST_ADDR   = 8'(N_W - 1);

    localparam logic signed [ACC_W-1:0] ONE_ACC = ACC_W'(1);
    localparam logic signed [ACC_W-1:0] HID_MAX = (ONE_ACC <<< (DATA_W - 1)) - ONE_ACC;
    localparam logic signed [ACC_W-1:0] HID_MIN = -(ONE_ACC <<< (DATA_W - 1));
    localparam logic signed [ACC_W-1:0] OUT_MAX = (ONE_ACC <<< (OUT_W - 1)) - ONE_ACC;
    localparam logic signed [ACC_W-1:0] OUT_MIN = -(ONE_ACC <<< (OUT_W - 1));

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_STORE} state_t;

    state_t state, state_next;
    logic   accept, mac_en, store_en, last_neuron;

    logic [4:0]               neuron;
    logic [3:0]               k;
    logic [7:0]               w_addr;
    logic signed [ACC_W-1:0]  acc, acc_sum, shifted;
    logic signed [PROD_W-1:0] prod;
    logic signed [DATA_W-1:0] op_sel, w_sel, hid_val;
    logic signed [OUT_W-1:0]  out_val;

    logic signed [DATA_W-1:0] in_buf  [N_IN];
    logic signed [DATA_W-1:0] buf_a   [N_IN];
    logic signed [DATA_W-1:0] buf_b   [N_IN];
    logic signed [DATA_W-1:0] weights [N_W];

    // NOTE: the weight memory deliberately has no reset; weights survive rst so an
    // aborted inference can be rerun without reloading them.
    always_ff @(posedge clk) begin
        if (cfg_we && !busy && (cfg_addr <= LAST_ADDR))
            weights[cfg_addr] <= cfg_wdata;
    end

    // The three weight regions are contiguous, so neuron*9+k addresses all of them.
    assign w_addr = 8'(neuron) * 8'(N_IN) + 8'(k);
    assign w_sel  = weights[w_addr];

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        op_sel = in_buf[k];
        if (neuron >= LAST_NEURON)
            op_sel = buf_b[k];
        else if (neuron >= FIRST_L1)
            op_sel = buf_a[k];
    end

    assign prod    = PROD_W'(op_sel) * PROD_W'(w_sel);
    assign acc_sum = acc + ACC_W'(prod);
    assign shifted = acc >>> FRAC_W;

    always_comb begin
        if (shifted > HID_MAX)
            hid_val = {1'b0, {(DATA_W-1){1'b1}}};
        else if (shifted < HID_MIN)
            hid_val = {1'b1, {(DATA_W-1){1'b0}}};
        else
            hid_val = shifted[DATA_W-1:0];
`ifdef NETWORK_SEQUENCER_RELU_EN
        if (hid_val[DATA_W-1])
            hid_val = '0;
`else
`endif
    end

    always_comb begin
        if (shifted > OUT_MAX)
            out_val = {1'b0, {(OUT_W-1){1'b1}}};
        else if (shifted < OUT_MIN)
            out_val = {1'b1, {(OUT_W-1){1'b0}}};
        else
            out_val = shifted[OUT_W-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments only; blocking ones here
    // would make the result depend on process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:  if (start) state_next = S_MAC;
            S_MAC:   if (k == LAST_K) state_next = S_STORE;
            S_STORE: state_next = (neuron == LAST_NEURON) ? S_IDLE : S_MAC;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        accept      = (state == S_IDLE) && start;
        mac_en      = (state == S_MAC);
        store_en    = (state == S_STORE);
        last_neuron = (neuron == LAST_NEURON);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            neuron <= '0;
            k      <= '0;
            busy   <= 1'b0;
            end_   <= 1'b0;
            out    <= '0;
            for (int i = 0; i < N_IN; i++) begin
                in_buf[i] <= '0;
                buf_a[i]  <= '0;
                buf_b[i]  <= '0;
            end
        end else begin
            end_ <= 1'b0;
            if (accept) begin
                in_buf[0] <= input_0;
                in_buf[1] <= input_1;
                in_buf[2] <= input_2;
                in_buf[3] <= input_3;
                in_buf[4] <= input_4;
                in_buf[5] <= input_5;
                in_buf[6] <= input_6;
                in_buf[7] <= input_7;
                in_buf[8] <= input_8;
                acc       <= '0;
                neuron    <= '0;
                k         <= '0;
                busy      <= 1'b1;
            end
            if (mac_en) begin
                acc <= acc_sum;
                k   <= (k == LAST_K) ? 4'd0 : k + 4'd1;
            end
            if (store_en) begin
                acc <= '0;
                if (last_neuron) begin
                    out  <= out_val;
                    busy <= 1'b0;
                    end_ <= 1'b1;
                end else begin
                    if (neuron < FIRST_L1)
                        buf_a[neuron[3:0]] <= hid_val;
                    else
                        buf_b[4'(neuron - FIRST_L1)] <= hid_val;
                    neuron <= neuron + 5'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_network_sequencer.sv
// Scoreboard bench for network_sequencer: expected results come from a loop-based
// matrix model of the 9-9-1 network; a monitor compares them whenever end_ pulses.
`timescale 1ns/1ps
module tb_network_sequencer;

    localparam logic signed [32:0] ONE = 33'sd67108864;
    localparam int LAT = 190;
    localparam logic signed [127:0] HMAX = 128'sd4294967295;
    localparam logic signed [127:0] HMIN = -128'sd4294967296;
    localparam logic signed [127:0] OMAX = 128'sd8589934591;
    localparam logic signed [127:0] OMIN = -128'sd8589934592;

    logic clk = 1'b0;
    logic rst, start, cfg_we;
    logic [7:0] cfg_addr;
    logic signed [32:0] cfg_wdata;
    logic signed [32:0] x_drv [9];
    logic busy, end_;
    logic signed [33:0] out;

    typedef struct {
        logic signed [63:0] exp_out;
        int                 acc_cyc;
    } sb_t;

    sb_t sb [$];
    logic signed [32:0] mw [171];
    logic signed [32:0] wv [171];
    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;

    network_sequencer dut (
        .clk(clk), .rst(rst), .start(start),
        .input_0(x_drv[0]), .input_1(x_drv[1]), .input_2(x_drv[2]),
        .input_3(x_drv[3]), .input_4(x_drv[4]), .input_5(x_drv[5]),
        .input_6(x_drv[6]), .input_7(x_drv[7]), .input_8(x_drv[8]),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .busy(busy), .out(out), .end_(end_)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain matrix-vector products on wide integers, floor shift, clamp.
    function automatic logic signed [63:0] ref_model(input logic signed [32:0] xv [9]);
        logic signed [127:0] layer [9];
        logic signed [127:0] nxt [9];
        logic signed [127:0] s, v, p;
        for (int n = 0; n < 9; n++) layer[n] = xv[n];
        for (int l = 0; l < 2; l++) begin
            for (int n = 0; n < 9; n++) begin
                s = 0;
                for (int j = 0; j < 9; j++) begin
                    p = mw[l*81 + n*9 + j];
                    s += layer[j] * p;
                end
                v = s >>> 26;
                if (v > HMAX) v = HMAX;
                else if (v < HMIN) v = HMIN;
`ifdef NETWORK_SEQUENCER_RELU_EN
                if (v < 0) v = 0;
`endif
                nxt[n] = v;
            end
            layer = nxt;
        end
        s = 0;
        for (int j = 0; j < 9; j++) begin
            p = mw[162 + j];
            s += layer[j] * p;
        end
        v = s >>> 26;
        if (v > OMAX) v = OMAX;
        else if (v < OMIN) v = OMIN;
        return v[63:0];
    endfunction

    function automatic bit model_busy_at(input int edge_no);
        foreach (sb[i])
            if (edge_no > sb[i].acc_cyc && edge_no <= sb[i].acc_cyc + LAT) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic signed [32:0] rand33(input int sh);
        logic [63:0] r;
        logic signed [32:0] v;
        r = {$urandom, $urandom};
        v = r[32:0];
        return v >>> sh;
    endfunction

    // Monitor: checks busy every cycle and pops the scoreboard on each end_ pulse.
    initial begin
        sb_t e;
        logic exp_busy;
        forever begin
            @(negedge clk);
            if (rst === 1'b0) begin
                exp_busy = 1'b0;
                if (sb.size() > 0)
                    exp_busy = (cyc >= sb[0].acc_cyc) && (cyc < sb[0].acc_cyc + LAT);
                check("busy", 64'(busy), 64'(exp_busy));
                if (end_ === 1'b1) begin
                    if (sb.size() == 0) begin
                        check("spurious_end", 64'(end_), 64'sd0);
                    end else begin
                        e = sb.pop_front();
                        check("out", 64'(out), e.exp_out);
                        check("latency", 64'(cyc - e.acc_cyc), 64'(LAT));
                    end
                end else if (sb.size() > 0 && cyc >= sb[0].acc_cyc + LAT) begin
                    check("end_missing", 64'(end_), 64'sd1);
                    void'(sb.pop_front());
                end
            end
        end
    end

    // Stimulus tasks are entered right after a falling edge.
    task automatic write_w(input int addr, input logic signed [32:0] val);
        int e;
        e = cyc + 1;
        cfg_we = 1'b1;
        cfg_addr = 8'(addr);
        cfg_wdata = val;
        if (addr <= 170 && !model_busy_at(e)) mw[addr] = val;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic load_all();
        for (int a = 0; a < 171; a++) write_w(a, wv[a]);
    endtask

    task automatic set_diag(input bool_out_all);
        for (int a = 0; a < 171; a++) wv[a] = '0;
        for (int n = 0; n < 9; n++) begin
            wv[n*9 + n] = ONE;
            wv[81 + n*9 + n] = ONE;
        end
        wv[162] = ONE;
        if (bool_out_all) for (int j = 0; j < 9; j++) wv[162 + j] = ONE;
    endtask

    task automatic set_x_ramp();
        for (int i = 0; i < 9; i++) x_drv[i] = ONE * 33'(i + 1);
    endtask

    task automatic launch(input logic signed [63:0] exp);
        sb_t ent;
        ent.exp_out = exp;
        ent.acc_cyc = cyc + 1;
        sb.push_back(ent);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 9; i++) x_drv[i] = rand33(0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 64'(sb.size()), 64'sd0);
        sb.delete();
        @(negedge clk);
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        while (end_ !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("end_wait", 64'(end_), 64'sd1);
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        cfg_we = 1'b0;
        cfg_addr = '0;
        cfg_wdata = '0;
        for (int i = 0; i < 9; i++) x_drv[i] = '0;
        for (int a = 0; a < 171; a++) mw[a] = '0;
        #1 rst = 1'b1;
        #2;
        check("reset_busy", 64'(busy), 64'sd0);
        check("reset_end", 64'(end_), 64'sd0);
        check("reset_out", 64'(out), 64'sd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Diagonal path with all output weights 1.0: out = 1+2+...+9 = 45.0.
        set_diag(1'b1);
        load_all();
        set_x_ramp();
        launch(64'sd3019898880);
        wait_idle();

        // Handshake: ignored starts while busy, dropped config write, back-to-back start.
        set_x_ramp();
        launch(64'sd3019898880);
        repeat (48) @(negedge clk);
        pulse_start();
        write_w(162, '0);
        repeat (68) @(negedge clk);
        pulse_start();
        wait_end();
        set_x_ramp();
        launch(64'sd3019898880);
        wait_idle();

        // Reset mid-inference: immediate abort, then a rerun on the retained weights.
        set_x_ramp();
        launch(64'sd3019898880);
        repeat (98) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        sb.delete();
        #1;
        check("abort_busy", 64'(busy), 64'sd0);
        check("abort_end", 64'(end_), 64'sd0);
        check("abort_out", 64'(out), 64'sd0);
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        set_x_ramp();
        launch(64'sd3019898880);
        wait_idle();

        // Saturation: each hidden neuron sums 72.0, clamped to 2^32-1.
        set_diag(1'b0);
        for (int a = 0; a < 81; a++) wv[a] = ONE;
        load_all();
        for (int i = 0; i < 9; i++) x_drv[i] = 33'sd536870912;
        launch(64'sd4294967295);
        wait_idle();

        // Negative hidden value: ReLU clips it, the linear build passes it through.
        set_diag(1'b0);
        load_all();
        for (int i = 0; i < 9; i++) x_drv[i] = '0;
        x_drv[0] = -33'sd201326592;
`ifdef NETWORK_SEQUENCER_RELU_EN
        launch(64'sd0);
`else
        launch(-64'sd201326592);
`endif
        wait_idle();

        // Randomized weights and inputs against the reference model.
        for (int t = 0; t < 8; t++) begin
            for (int a = 0; a < 171; a++) wv[a] = rand33($urandom_range(5, 9));
            load_all();
            write_w(171 + $urandom_range(0, 84), rand33(0));
            for (int i = 0; i < 9; i++) x_drv[i] = rand33($urandom_range(0, 10));
            launch(ref_model(x_drv));
            wait_idle();
        end

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
